// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray helpers for the FIFO pointer/flag logic.
package fifo_pkg;

  localparam int MAX_PW = 13;

  typedef logic [MAX_PW-1:0] ptr_t;
  typedef logic [MAX_PW-2:0] addr_t;

  // Sized for the widest legal pointer; callers cast down to their own width.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary conversion of a W-bit code.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of its Gray bit and every higher Gray bit.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wptr_full_prog.sv
// Write-side pointer, full/almost-full flags, fill level and sticky overflow
// for an asynchronous FIFO with a programmable almost-full threshold.
module wptr_full_prog
  import fifo_pkg::*;
#(
  parameter int ASIZE      = 4,
  parameter int AF_DEFAULT = 2**ASIZE - 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             af_load,
  input  logic [ASIZE:0]   af_level,
  input  logic             wovf_clr,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             wafull,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);

  localparam logic [ASIZE:0] DEPTH = (ASIZE+1)'(1) << ASIZE;

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] wbnext;
  logic [ASIZE:0] wgnext;
  logic [ASIZE:0] rbin;
  logic [ASIZE:0] level_next;
  logic [ASIZE:0] threshold;
  logic [ASIZE:0] af_clamped;
  logic [ASIZE:0] thr_eff;
  logic           full_next;
  logic           afull_next;

  gray2bin #(.W(ASIZE+1)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign wen   = winc & ~wfull & ~wrst;
  assign waddr = wbin[ASIZE-1:0];

  // A threshold being loaded this cycle already governs the flag registered now.
  always_comb begin
    af_clamped = af_level;
    if (af_level == '0) begin
      af_clamped = (ASIZE+1)'(1);
    end else if (af_level > DEPTH) begin
      af_clamped = DEPTH;
    end
    thr_eff    = af_load ? af_clamped : threshold;
    wbnext     = wbin + (ASIZE+1)'(wen);
    wgnext     = (ASIZE+1)'(bin2gray(ptr_t'(wbnext)));
    level_next = wbnext - rbin;
    full_next  = (wgnext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
    afull_next = (level_next >= thr_eff);
  end

  // Overflow set takes priority over a simultaneous clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      wafull    <= 1'b0;
      wlevel    <= '0;
      woverflow <= 1'b0;
      threshold <= (ASIZE+1)'(AF_DEFAULT);
    end else begin
      wbin   <= wbnext;
      wptr   <= wgnext;
      wfull  <= full_next;
      wafull <= afull_next;
      wlevel <= level_next;
      if (af_load) begin
        threshold <= af_clamped;
      end
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (wovf_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wptr_full_prog.md
WPTR_FULL_PROG -- requirements
Module: wptr_full_prog

Interface
REQ-001 Parameter ASIZE, default 4; address width, FIFO depth = 2**ASIZE, legal range 2..12.
REQ-002 Parameter AF_DEFAULT, default 2**ASIZE-2; almost-full threshold loaded at reset.
REQ-003 Port wclk, input, 1: write-domain clock; all state on rising edge.
REQ-004 Port wrst, input, 1: reset, synchronous to wclk, active-high.
REQ-005 Port winc, input, 1: write request.
REQ-006 Port wq2_rptr, input, ASIZE+1: Gray read pointer, already synchronised into wclk by an external 2-flop stage.
REQ-007 Port af_load, input, 1: load af_level into threshold register.
REQ-008 Port af_level, input, ASIZE+1: new almost-full threshold, 1..2**ASIZE.
REQ-009 Port wovf_clr, input, 1: clear sticky overflow.
REQ-010 Port wen, output, 1: write accepted this cycle (RAM write enable).
REQ-011 Port waddr, output, ASIZE: RAM write address.
REQ-012 Port wptr, output, ASIZE+1: registered Gray write pointer for the read domain.
REQ-013 Port wfull, output, 1: registered full flag.
REQ-014 Port wafull, output, 1: registered almost-full flag.
REQ-015 Port wlevel, output, ASIZE+1: registered fill level as seen from write side, 0..2**ASIZE.
REQ-016 Port woverflow, output, 1: sticky, write attempted while full.

Function
REQ-017 wen SHALL be combinational winc & ~wfull; sole combinational output.
REQ-018 wbin (ASIZE+1-bit binary) SHALL advance by 1 on wen, wrapping 2**(ASIZE+1)-1 -> 0; waddr = wbin[ASIZE-1:0].
REQ-019 wptr SHALL equal Gray(wbin) registered, with exactly one bit change per increment.
REQ-020 rbin SHALL be the binary conversion of wq2_rptr, combinational, zero added latency.
REQ-021 wfull SHALL be registered as Gray(wbnext) == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}; asserts the edge the 2**ASIZE-th unread write is accepted.
REQ-022 wlevel SHALL be registered as (wbnext - rbin) mod 2**(ASIZE+1).
REQ-023 wafull SHALL be registered as (wbnext - rbin) >= threshold; wfull implies wafull.
REQ-024 Flags release only through wq2_rptr advance: pessimistic, never falsely deasserted.
REQ-025 winc while wfull SHALL not move wbin/wptr and SHALL set woverflow next edge.
REQ-026 wovf_clr and a new overflow event in the same cycle: set wins.
REQ-027 af_load SHALL update threshold next edge; flags use the new value from that edge onward; af_level 0 clamps to 1, >2**ASIZE clamps to 2**ASIZE.
REQ-028 Read pointer advancing in the same cycle as a write SHALL give level = old level, no flag glitch.

Reset
REQ-029 wrst high at a wclk edge: wbin, wptr, wlevel = 0; wfull, wafull, woverflow = 0; threshold = AF_DEFAULT.
REQ-030 Reset mid-operation SHALL abandon contents; wen forced 0 while wrst high.
REQ-031 First write accepted the cycle after wrst deasserts.

Structure
REQ-032 Package fifo_pkg SHALL hold ptr_t/addr_t widths and bin2gray function.
REQ-033 Sub-module gray2bin (parameter W) SHALL perform the rptr conversion; instantiated once.
REQ-034 No memory inside; no CDC flops inside.

Verification (ASIZE=4, depth 16, AF_DEFAULT=14)
REQ-035 Reset, wq2_rptr=0, 16 consecutive winc -> wen high 16 cycles, wfull=1 after 16th edge, wlevel=16, wptr=5'b11000.
REQ-036 Full, winc held 3 more cycles -> wen=0, wptr unchanged, woverflow=1 stays; wovf_clr pulse -> 0.
REQ-037 14 writes, rptr=0 -> wafull set after 14th edge, wfull=0; af_load af_level=10 -> wafull still 1, af_level=15 -> wafull=0.
REQ-038 Full, wq2_rptr steps Gray(1) -> wfull=0, wlevel=15 next edge; one write -> wfull=1.
REQ-039 Run 40 writes with reads tracking 2 behind -> wptr wraps 31->0, one-bit Gray changes, wlevel=2 steady.
REQ-040 wrst at wlevel=9, winc high -> all outputs 0 next edge, threshold back to 14.
